// File: rtl/crop_video_pkg.sv
// Shared types and defaults for the AXI4-Stream video crop engine.
package crop_video_pkg;

   localparam int DATA_W_DEF  = 24;
   localparam int COORD_W_DEF = 12;

   typedef enum logic [0:0] {
      WAIT_SOF = 1'b0,
      ACTIVE   = 1'b1
   } crop_state_t;

   typedef struct packed {
      logic [COORD_W_DEF-1:0] x0;
      logic [COORD_W_DEF-1:0] y0;
      logic [COORD_W_DEF-1:0] w;
      logic [COORD_W_DEF-1:0] h;
   } crop_cfg_t;

   typedef struct packed {
      logic [DATA_W_DEF-1:0] data;
      logic                  user;
      logic                  last;
   } axis_beat_t;

   // Increment that sticks at all-ones so long lines never wrap back into the window.
   function automatic logic [COORD_W_DEF-1:0] sat_inc(input logic [COORD_W_DEF-1:0] v);
      return (&v) ? v : v + COORD_W_DEF'(1);
   endfunction

endpackage

// File: rtl/crop_video_out_reg.sv
// Single-entry AXIS output register; holds its beat until the sink takes it.
module crop_video_out_reg
   import crop_video_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  axis_beat_t load_beat,
   output logic       s_ready,
   output logic [DATA_W_DEF-1:0] m_tdata,
   output logic       m_tvalid,
   input  logic       m_tready,
   output logic       m_tuser,
   output logic       m_tlast
);

   // Valid/ready: a beat moves when valid and ready are both high at a clock edge;
   // valid never drops and data never changes while the beat waits for ready.
   assign s_ready = !m_tvalid | m_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         m_tvalid <= 1'b0;
         m_tdata  <= '0;
         m_tuser  <= 1'b0;
         m_tlast  <= 1'b0;
      end else if (load) begin
         m_tvalid <= 1'b1;
         m_tdata  <= load_beat.data;
         m_tuser  <= load_beat.user;
         m_tlast  <= load_beat.last;
      end else if (m_tready) begin
         m_tvalid <= 1'b0;
      end
   end

endmodule

// File: rtl/crop_video_core.sv
// AXIS video crop: tracks raster position, keeps pixels inside a programmable
// window and regenerates SOF/EOL for the cropped frame.
module crop_video_core
   import crop_video_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int COORD_W = COORD_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [DATA_W-1:0]  s_axis_tdata,
   input  logic               s_axis_tvalid,
   output logic               s_axis_tready,
   input  logic               s_axis_tuser,
   input  logic               s_axis_tlast,
   output logic [DATA_W-1:0]  m_axis_tdata,
   output logic               m_axis_tvalid,
   input  logic               m_axis_tready,
   output logic               m_axis_tuser,
   output logic               m_axis_tlast,
   input  logic [COORD_W-1:0] cfg_x0,
   input  logic [COORD_W-1:0] cfg_y0,
   input  logic [COORD_W-1:0] cfg_w,
   input  logic [COORD_W-1:0] cfg_h,
   output logic               frame_err
);

   localparam int SW = COORD_W + 1;

   crop_state_t        state, state_nxt;
   logic [COORD_W-1:0] x, y;
   logic [COORD_W-1:0] cur_x, cur_y;
   crop_cfg_t          cfg_q, cfg_eff;
   logic               sof_sent;
   logic               accept, is_sof, process;
   logic [SW-1:0]      x_end, y_end;
   logic               in_x, in_y;
   logic               keep;
   axis_beat_t         keep_beat;

   assign accept  = s_axis_tvalid & s_axis_tready;
   assign is_sof  = accept & s_axis_tuser;
   assign process = accept & ((state == ACTIVE) | s_axis_tuser);

   // An SOF beat is pixel (0,0) of a new frame and sees the live config.
   always_comb begin
      cur_x   = x;
      cur_y   = y;
      cfg_eff = cfg_q;
      if (s_axis_tuser) begin
         cur_x   = '0;
         cur_y   = '0;
         cfg_eff = '{x0: cfg_x0, y0: cfg_y0, w: cfg_w, h: cfg_h};
      end
   end

   // Window ends carry one extra bit so a window reaching the coordinate limit does not wrap.
   assign x_end = {1'b0, cfg_eff.x0} + {1'b0, cfg_eff.w};
   assign y_end = {1'b0, cfg_eff.y0} + {1'b0, cfg_eff.h};
   assign in_x  = (cur_x >= cfg_eff.x0) & ({1'b0, cur_x} < x_end);
   assign in_y  = (cur_y >= cfg_eff.y0) & ({1'b0, cur_y} < y_end);
   assign keep  = process & in_x & in_y;

   always_comb begin
      keep_beat.data = s_axis_tdata;
      keep_beat.user = s_axis_tuser | !sof_sent;
      keep_beat.last = s_axis_tlast | ({1'b0, cur_x} == (x_end - SW'(1)));
   end

   always_comb begin
      state_nxt = state;
      if (is_sof) state_nxt = ACTIVE;
   end

   always_ff @(posedge clk) begin
      if (rst) state <= WAIT_SOF;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         x         <= '0;
         y         <= '0;
         cfg_q     <= '0;
         sof_sent  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         frame_err <= is_sof & (state == ACTIVE) & (x != '0);
         if (process) begin
            if (s_axis_tlast) begin
               x <= '0;
               y <= sat_inc(cur_y);
            end else begin
               x <= sat_inc(cur_x);
               y <= cur_y;
            end
         end
         if (is_sof) cfg_q <= cfg_eff;
         if (keep)        sof_sent <= 1'b1;
         else if (is_sof) sof_sent <= 1'b0;
      end
   end

   crop_video_out_reg u_out_reg (
      .clk       (clk),
      .rst       (rst),
      .load      (keep),
      .load_beat (keep_beat),
      .s_ready   (s_axis_tready),
      .m_tdata   (m_axis_tdata),
      .m_tvalid  (m_axis_tvalid),
      .m_tready  (m_axis_tready),
      .m_tuser   (m_axis_tuser),
      .m_tlast   (m_axis_tlast)
   );

endmodule

// File: tb/tb_crop_video_core.sv
// Bench for crop_video_core: random pixels and stalls against a raster-level window model.
module tb_crop_video_core;

   localparam int DW = 24;
   localparam int CW = 12;
   localparam int CMAX = 4095;

   logic          clk;
   logic          rst;
   logic [DW-1:0] s_data;
   logic          s_valid;
   logic          s_ready;
   logic          s_user;
   logic          s_last;
   logic [DW-1:0] m_data;
   logic          m_valid;
   logic          m_ready;
   logic          m_user;
   logic          m_last;
   logic [CW-1:0] cfg_x0, cfg_y0, cfg_w, cfg_h;
   logic          frame_err;

   int n_checks = 0;
   int n_pass   = 0;
   int err_pulses = 0;
   int out_cnt  = 0;
   int sink_mode = 0;
   logic [DW+1:0] exp_q[$];
   logic [DW-1:0] pix[$];
   logic          held_v = 1'b0;
   logic [DW+1:0] held;

   crop_video_core dut (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_data), .s_axis_tvalid(s_valid), .s_axis_tready(s_ready),
      .s_axis_tuser(s_user), .s_axis_tlast(s_last),
      .m_axis_tdata(m_data), .m_axis_tvalid(m_valid), .m_axis_tready(m_ready),
      .m_axis_tuser(m_user), .m_axis_tlast(m_last),
      .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_w(cfg_w), .cfg_h(cfg_h),
      .frame_err(frame_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("check %s", tag);
      end
   endtask

   // Sink: ready pattern selected by sink_mode, changed just after each edge.
   always begin
      @(posedge clk);
      #1;
      case (sink_mode)
         0:       m_ready = 1'b1;
         1:       m_ready = ~m_ready;
         2:       m_ready = 1'($urandom_range(0, 1));
         default: m_ready = 1'b0;
      endcase
   end

   // Scoreboard and handshake monitor, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         held_v = 1'b0;
      end else begin
         if (frame_err) err_pulses++;
         if (held_v) check("held_beat_stable", {m_valid, m_data, m_user, m_last}, {1'b1, held});
         if (m_valid && !m_ready) check("s_ready_low_while_held", s_ready, 0);
         held_v = m_valid && !m_ready;
         held   = {m_data, m_user, m_last};
         if (m_valid && m_ready) begin
            out_cnt++;
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_beat observed=%h expected=none", {m_data, m_user, m_last});
            end else begin
               check("out_beat", {m_data, m_user, m_last}, exp_q.pop_front());
            end
         end
      end
   end

   // Entered and left at 1 time unit after a rising edge.
   task automatic send_beat(input logic [DW-1:0] d, input logic u, input logic l, input bit gaps);
      bit done = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
         @(posedge clk);
         #1;
      end
      s_data  = d;
      s_user  = u;
      s_last  = l;
      s_valid = 1'b1;
      for (int t = 0; t < 1000 && !done; t++) begin
         @(negedge clk);
         if (s_ready) done = 1;
         @(posedge clk);
         #1;
      end
      s_valid = 1'b0;
      s_user  = 1'b0;
      s_last  = 1'b0;
      if (!done) begin
         n_checks++;
         $display("FAIL send_timeout observed=not_accepted expected=accepted");
      end
   endtask

   // Raster of fw x fh pixels (first nbeats only); expectations come straight from window geometry.
   task automatic run_frame(input int fw, input int fh, input int nbeats,
                            input int x0, input int y0, input int w, input int h,
                            input int mid_w, input bit gaps);
      bit first = 1;
      cfg_x0 = CW'(x0);
      cfg_y0 = CW'(y0);
      cfg_w  = CW'(w);
      cfg_h  = CW'(h);
      pix.delete();
      for (int i = 0; i < nbeats && i < fw * fh; i++) begin
         int px, py, kx, ky;
         logic [DW-1:0] p;
         px = i % fw;
         py = i / fw;
         kx = (px > CMAX) ? CMAX : px;
         ky = (py > CMAX) ? CMAX : py;
         p  = DW'($urandom);
         pix.push_back(p);
         if (kx >= x0 && kx < x0 + w && ky >= y0 && ky < y0 + h) begin
            exp_q.push_back({p, first, (kx == x0 + w - 1) || (px == fw - 1)});
            first = 0;
         end
      end
      for (int i = 0; i < pix.size(); i++) begin
         send_beat(pix[i], i == 0, (i % fw) == fw - 1, gaps);
         if (mid_w >= 0 && i == fw - 1) cfg_w = CW'(mid_w);
      end
   endtask

   task automatic drain(input string tag);
      for (int t = 0; t < 2000 && exp_q.size() != 0; t++) @(posedge clk);
      repeat (3) @(posedge clk);
      #1;
      check(tag, exp_q.size(), 0);
   endtask

   initial begin
      rst = 1'b1;
      s_valid = 1'b0; s_user = 1'b0; s_last = 1'b0; s_data = '0;
      m_ready = 1'b1;
      cfg_x0 = '0; cfg_y0 = '0; cfg_w = '0; cfg_h = '0;
      sink_mode = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_tvalid", m_valid, 0);
      check("rst_tuser", m_user, 0);
      check("rst_tlast", m_last, 0);
      check("rst_tdata", m_data, 0);
      check("rst_frame_err", frame_err, 0);
      check("rst_s_ready", s_ready, 1);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Basic window, sink always ready
      out_cnt = 0; err_pulses = 0;
      run_frame(8, 4, 32, 2, 1, 3, 2, -1, 0);
      drain("t1_drain");
      check("t1_count", out_cnt, 6);

      // Sink toggling, input always valid
      sink_mode = 1; out_cnt = 0;
      run_frame(8, 4, 32, 2, 1, 3, 2, -1, 0);
      drain("t2_drain");
      check("t2_count", out_cnt, 6);

      // Window clipped by right frame edge
      sink_mode = 2; out_cnt = 0;
      run_frame(8, 4, 32, 6, 0, 5, 1, -1, 1);
      drain("t3_drain");
      check("t3_count", out_cnt, 2);

      // Empty window, mid-frame config change ignored until next SOF
      sink_mode = 0; out_cnt = 0;
      run_frame(8, 4, 32, 1, 1, 0, 2, 2, 1);
      drain("t4a_drain");
      check("t4a_count", out_cnt, 0);
      out_cnt = 0;
      run_frame(8, 4, 32, 1, 1, 2, 2, -1, 1);
      drain("t4b_drain");
      check("t4b_count", out_cnt, 4);
      check("t1_t4_no_frame_err", err_pulses, 0);

      // SOF injected at x=3 of line 2
      sink_mode = 2; out_cnt = 0; err_pulses = 0;
      run_frame(8, 4, 8 * 2 + 3, 1, 1, 4, 3, -1, 1);
      run_frame(8, 4, 32, 1, 1, 4, 3, -1, 1);
      drain("t5_drain");
      check("t5_count", out_cnt, 18);
      check("t5_frame_err_pulses", err_pulses, 1);

      // Reset with a held output beat and stalled sink
      sink_mode = 3;
      @(posedge clk);
      #1;
      cfg_x0 = '0; cfg_y0 = '0; cfg_w = CW'(2); cfg_h = CW'(1);
      s_data = DW'($urandom); s_user = 1'b1; s_last = 1'b0; s_valid = 1'b1;
      @(posedge clk);
      #1;
      s_valid = 1'b0; s_user = 1'b0;
      @(negedge clk);
      check("t6_valid_before_rst", m_valid, 1);
      check("t6_user_before_rst", m_user, 1);
      @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check("t6_valid_after_rst", m_valid, 0);
      sink_mode = 0; out_cnt = 0;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) send_beat(DW'($urandom), 1'b0, i == 4, 1);
      drain("t6a_drain");
      check("t6_discard_count", out_cnt, 0);
      run_frame(8, 4, 32, 0, 0, 8, 1, -1, 0);
      drain("t6b_drain");
      check("t6_count", out_cnt, 8);

      // Window end beyond coordinate limit must not wrap
      sink_mode = 2; out_cnt = 0;
      run_frame(8, 2, 16, 5, 0, CMAX, CMAX, -1, 1);
      drain("t7_drain");
      check("t7_count", out_cnt, 6);

      // Line longer than coordinate range saturates x
      sink_mode = 0; out_cnt = 0;
      run_frame(4100, 1, 4100, CMAX, 0, 1, 1, -1, 0);
      drain("t8_drain");
      check("t8_count", out_cnt, 5);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/crop_video_core.md
Name: crop_video_core

Overview:
AXI4-Stream video crop engine; the DUT stage that drives the crop_video AXIS sink interface.
- Accepts raster video on a slave AXIS port: tuser = start-of-frame (SOF), tlast = end-of-line (EOL).
- Forwards only pixels inside a programmable rectangular window, on a master AXIS port.
- Regenerates tuser/tlast for the cropped frame; one-cycle registered output.

Parameters:
DATA_W, 24, pixel width in bits (tdata).
COORD_W, 12, width of coordinate/size fields and internal x/y counters.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
s_axis_tdata  input  DATA_W  input pixel
s_axis_tvalid  input  1  input beat valid
s_axis_tready  output  1  input beat accepted when high with tvalid
s_axis_tuser  input  1  SOF marker on first pixel of frame
s_axis_tlast  input  1  EOL marker on last pixel of line
m_axis_tdata  output  DATA_W  cropped pixel
m_axis_tvalid  output  1  output beat valid
m_axis_tready  input  1  sink ready
m_axis_tuser  output  1  SOF of cropped frame
m_axis_tlast  output  1  EOL of cropped line
cfg_x0  input  COORD_W  window left column
cfg_y0  input  COORD_W  window top row
cfg_w  input  COORD_W  window width in pixels
cfg_h  input  COORD_W  window height in lines
frame_err  output  1  one-cycle pulse: SOF received with x != 0 (mid-line resync)

Behaviour:
- Clocking: single clock clk; rst is synchronous and active-high.
- Reset values: m_axis_tvalid=0, m_axis_tuser=0, m_axis_tlast=0, m_axis_tdata=0, frame_err=0; state=WAIT_SOF; x=0, y=0.
- Handshake:
  - Beat accepted = s_axis_tvalid & s_axis_tready.
  - s_axis_tready = !m_axis_tvalid | m_axis_tready (combinational).
  - Output register holds data stable while m_axis_tvalid & !m_axis_tready; no beat dropped or duplicated.
- States:
  - WAIT_SOF: accepted beats without tuser are discarded. An accepted beat with tuser -> ACTIVE and is processed as pixel (0,0).
  - ACTIVE: every accepted beat is processed.
  - No other states.
- Config latch: cfg_* sampled into shadow registers on the accepted SOF beat only. Changes mid-frame take effect next frame.
- Counters (per processed beat):
  - tuser: pixel coordinate (0,0).
  - Otherwise: tlast -> x=0, y=y+1; else x=x+1.
  - Coordinates used for the keep test are the pre-update values.
  - Counters saturate at all-ones; no wrap.
- Keep test: x0<=x<x0+w and y0<=y<y0+h. Sums are computed at COORD_W+1 bits, so windows at the coordinate limit do not wrap.
- Kept beat loads the output register, m_axis_tvalid=1 next cycle (latency 1).
  - m_axis_tuser=1 on the first kept beat of a frame only; a per-frame flag is cleared by the accepted SOF.
  - m_axis_tlast=1 if x==x0+w-1 or the input beat has tlast (window clipped by the right frame edge).
- Dropped beats are still accepted (consume tready) but leave the output register unchanged.
- Empty window: w==0 or h==0 -> no output for that frame.
- SOF in ACTIVE:
  - Always resyncs: counters restart at (0,0) and config is re-latched.
  - frame_err pulses the cycle after acceptance if the previous x != 0.
- An input line longer than the coordinate range saturates x; no pixels beyond are kept unless the window covers the saturated value.
- rst mid-frame: output beat abandoned (tvalid low next cycle), state returns to WAIT_SOF.

Decomposition:
- Shared package crop_video_pkg holds:
  - DATA_W/COORD_W defaults
  - state enum (WAIT_SOF, ACTIVE)
  - packed struct crop_cfg_t {x0,y0,w,h}
  - packed struct axis_beat_t {data,user,last}
- One natural sub-module: crop_video_out_reg, the single-entry AXIS output register/handshake.
- Keep test and counters stay in the top module.

Test Plan:
1. 8x4 frame, window x0=2,y0=1,w=3,h=2, sink always ready -> 6 beats: (2,1) tuser=1; (4,1) tlast; (2,2) tuser=0; (4,2) tlast.
2. Same frame, m_axis_tready toggled 1010..., input always valid -> identical 6 beats in order; s_axis_tready low whenever output is held.
3. 8x4 frame, window x0=6,w=5,h=1,y0=0 -> beats x=6,7; tlast on x=7 (from input EOL); no output on other lines.
4. cfg_w=0, then next frame cfg_w=2 applied mid-frame -> first frame zero output; change ignored until next SOF, then 2 pixels per window line.
5. SOF injected at x=3 of line 2 -> frame_err single pulse; cropping restarts from (0,0); next kept beat has tuser=1.
6. rst asserted for 1 cycle with m_axis_tvalid=1 and sink stalled -> m_axis_tvalid=0 next cycle; beats before the next SOF discarded.
